// File: rtl/rs_pool.sv
// rs_pool: reservation-station pool with CDB snooping, issue-time bypass and one dispatch per cycle; issue/dispatch/free act at the next edge.
// disp_ready low holds the presented entry; defining RS_POOL_AGE_ORDER_EN dispatches oldest-ready instead of lowest-index-ready.
module rs_pool #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_WIDTH   = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_BASE    = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             issue_valid,
   input  logic [2:0]                       issue_op,
   input  logic [DATA_WIDTH-1:0]            issue_vj,
   input  logic [DATA_WIDTH-1:0]            issue_vk,
   input  logic [TAG_WIDTH-1:0]             issue_qj,
   input  logic [TAG_WIDTH-1:0]             issue_qk,
   output logic                             issue_ready,
   output logic [TAG_WIDTH-1:0]             issue_tag,
   input  logic                             cdb_valid,
   input  logic [TAG_WIDTH-1:0]             cdb_tag,
   input  logic [DATA_WIDTH-1:0]            cdb_data,
   output logic                             disp_valid,
   output logic [2:0]                       disp_op,
   output logic [DATA_WIDTH-1:0]            disp_vj,
   output logic [DATA_WIDTH-1:0]            disp_vk,
   output logic [TAG_WIDTH-1:0]             disp_tag,
   input  logic                             disp_ready,
   input  logic                             flush,
   output logic [NUM_ENTRIES-1:0]           busy_vec,
   output logic [$clog2(NUM_ENTRIES+1)-1:0] free_count
);
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} st_t;

   st_t                   r_state [NUM_ENTRIES];
   logic [2:0]            r_op    [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] r_vj    [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] r_vk    [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]  r_qj    [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]  r_qk    [NUM_ENTRIES];

   st_t                   w_state_nxt [NUM_ENTRIES];
   logic [2:0]            w_op_nxt    [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] w_vj_nxt    [NUM_ENTRIES];
   logic [DATA_WIDTH-1:0] w_vk_nxt    [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]  w_qj_nxt    [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]  w_qk_nxt    [NUM_ENTRIES];

`ifdef RS_POOL_AGE_ORDER_EN
   // r_age[i][j] set means entry i was issued before entry j
   logic [NUM_ENTRIES-1:0] r_age     [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] w_age_nxt [NUM_ENTRIES];
`endif

   logic [NUM_ENTRIES-1:0] w_free_vec;
   logic [NUM_ENTRIES-1:0] w_ready_vec;
   logic [NUM_ENTRIES-1:0] w_sel_ok;
   logic [CNT_W-1:0]       w_count;
   logic [IDX_W-1:0]       w_free_idx;
   logic [IDX_W-1:0]       w_disp_idx;
   logic                   w_cdb_hit;
   logic                   w_issue_fire;
   logic                   w_disp_valid;
   logic                   w_disp_fire;
   logic [DATA_WIDTH-1:0]  w_iss_vj;
   logic [DATA_WIDTH-1:0]  w_iss_vk;
   logic [TAG_WIDTH-1:0]   w_iss_qj;
   logic [TAG_WIDTH-1:0]   w_iss_qk;

   function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [IDX_W-1:0] idx);
      return TAG_WIDTH'(TAG_BASE) + TAG_WIDTH'(idx);
   endfunction

   always_comb begin
      w_free_vec  = '0;
      w_ready_vec = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         w_free_vec[i]  = (r_state[i] == ST_FREE);
         w_ready_vec[i] = (r_state[i] == ST_READY);
      end
   end

   always_comb begin
      w_count = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         w_count = w_count + CNT_W'(w_free_vec[i]);
   end

   always_comb begin
      w_free_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (w_free_vec[i]) w_free_idx = IDX_W'(i);
   end

   always_comb begin
      w_sel_ok = w_ready_vec;
`ifdef RS_POOL_AGE_ORDER_EN
      for (int i = 0; i < NUM_ENTRIES; i++)
         for (int j = 0; j < NUM_ENTRIES; j++)
            if (j != i && w_ready_vec[j] && !r_age[i][j]) w_sel_ok[i] = 1'b0;
`endif
   end

   always_comb begin
      w_disp_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (w_sel_ok[i]) w_disp_idx = IDX_W'(i);
   end

   assign w_cdb_hit    = cdb_valid && (cdb_tag != '0);
   assign issue_ready  = (|w_free_vec) && !flush;
   assign issue_tag    = tag_of(w_free_idx);
   assign w_issue_fire = issue_valid && issue_ready;
   assign w_disp_valid = |w_ready_vec;
   assign w_disp_fire  = w_disp_valid && disp_ready && !flush;

   // A result broadcast in the issue cycle would otherwise be missed forever
   assign w_iss_vj = (w_cdb_hit && issue_qj == cdb_tag) ? cdb_data : issue_vj;
   assign w_iss_qj = (w_cdb_hit && issue_qj == cdb_tag) ? '0 : issue_qj;
   assign w_iss_vk = (w_cdb_hit && issue_qk == cdb_tag) ? cdb_data : issue_vk;
   assign w_iss_qk = (w_cdb_hit && issue_qk == cdb_tag) ? '0 : issue_qk;

   assign disp_valid = w_disp_valid;
   assign disp_op    = w_disp_valid ? r_op[w_disp_idx] : '0;
   assign disp_vj    = w_disp_valid ? r_vj[w_disp_idx] : '0;
   assign disp_vk    = w_disp_valid ? r_vk[w_disp_idx] : '0;
   assign disp_tag   = w_disp_valid ? tag_of(w_disp_idx) : '0;
   assign busy_vec   = ~w_free_vec;
   assign free_count = w_count;

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_vj_nxt    = r_vj;
      w_vk_nxt    = r_vk;
      w_qj_nxt    = r_qj;
      w_qk_nxt    = r_qk;
`ifdef RS_POOL_AGE_ORDER_EN
      w_age_nxt   = r_age;
`endif
      if (flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) w_state_nxt[i] = ST_FREE;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            case (r_state[i])
               ST_WAIT: begin
                  if (w_cdb_hit && r_qj[i] == cdb_tag) begin
                     w_vj_nxt[i] = cdb_data;
                     w_qj_nxt[i] = '0;
                  end
                  if (w_cdb_hit && r_qk[i] == cdb_tag) begin
                     w_vk_nxt[i] = cdb_data;
                     w_qk_nxt[i] = '0;
                  end
                  if (w_qj_nxt[i] == '0 && w_qk_nxt[i] == '0) w_state_nxt[i] = ST_READY;
               end
               ST_READY:
                  if (w_disp_fire && w_disp_idx == IDX_W'(i)) w_state_nxt[i] = ST_EXEC;
               ST_EXEC:
                  if (w_cdb_hit && cdb_tag == tag_of(IDX_W'(i))) w_state_nxt[i] = ST_FREE;
               default: ;
            endcase
         end
         if (w_issue_fire) begin
            w_op_nxt[w_free_idx]    = issue_op;
            w_vj_nxt[w_free_idx]    = w_iss_vj;
            w_vk_nxt[w_free_idx]    = w_iss_vk;
            w_qj_nxt[w_free_idx]    = w_iss_qj;
            w_qk_nxt[w_free_idx]    = w_iss_qk;
            w_state_nxt[w_free_idx] = (w_iss_qj == '0 && w_iss_qk == '0) ? ST_READY : ST_WAIT;
`ifdef RS_POOL_AGE_ORDER_EN
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               w_age_nxt[j][w_free_idx] = 1'b1;
               w_age_nxt[w_free_idx][j] = 1'b0;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_state[i] <= ST_FREE;
            r_op[i]    <= '0;
            r_vj[i]    <= '0;
            r_vk[i]    <= '0;
            r_qj[i]    <= '0;
            r_qk[i]    <= '0;
`ifdef RS_POOL_AGE_ORDER_EN
            r_age[i]   <= '0;
`endif
         end
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_vj    <= w_vj_nxt;
         r_vk    <= w_vk_nxt;
         r_qj    <= w_qj_nxt;
         r_qk    <= w_qk_nxt;
`ifdef RS_POOL_AGE_ORDER_EN
         r_age   <= w_age_nxt;
`endif
      end
   end

endmodule

// File: doc/rs_pool.md
RS_POOL -- requirements
Module: rs_pool

Interface
REQ-001 Parameter NUM_ENTRIES, default 4: number of reservation-station entries, 2..8.
REQ-002 Parameter TAG_WIDTH, default 4: width of every tag.
REQ-003 Parameter DATA_WIDTH, default 32: width of every operand and data bus.
REQ-004 Parameter TAG_BASE, default 1: tag of entry i is TAG_BASE+i; tag 0 means "no tag / value present".
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Issue inputs: issue_valid (1), issue_op (3), issue_vj and issue_vk (DATA_WIDTH each), issue_qj and issue_qk (TAG_WIDTH each).
REQ-008 Issue outputs: issue_ready (1), the "entry free" indication; issue_tag (TAG_WIDTH), the tag that the current issue would allocate.
REQ-009 CDB snoop inputs: cdb_valid (1), cdb_tag (TAG_WIDTH), cdb_data (DATA_WIDTH).
REQ-010 Dispatch outputs: disp_valid (1), disp_op (3), disp_vj and disp_vk (DATA_WIDTH each), disp_tag (TAG_WIDTH).
REQ-011 Dispatch input: disp_ready (1), the functional-unit accept signal.
REQ-012 flush, input, 1 bit: synchronous discard of every entry.
REQ-013 Status outputs: busy_vec (NUM_ENTRIES bits, bit i set when entry i is not FREE); free_count ($clog2(NUM_ENTRIES+1) bits).

Function
REQ-014 Each entry SHALL hold one state: FREE, WAIT (at least one qj/qk nonzero), READY (both operands present), or EXEC (dispatched, result pending).
REQ-015 issue_ready SHALL equal (any entry FREE) AND NOT flush; issue_tag SHALL be the tag of the lowest-index FREE entry, and TAG_BASE when no entry is FREE.
REQ-016 An issue fires when issue_valid and issue_ready are both high at the clock edge; the selected entry becomes WAIT or READY on the next cycle.
REQ-017 Issue-time bypass: when cdb_valid is high and cdb_tag is nonzero and equals issue_qj (or issue_qk), the entry SHALL capture cdb_data and store q=0 for that operand.
REQ-018 A WAIT entry whose qj or qk equals a valid nonzero cdb_tag SHALL capture cdb_data and clear that q at the edge; it becomes READY no earlier than the next cycle.
REQ-019 disp_valid SHALL be high when any entry is READY; disp_* SHALL present the selected entry (selection per REQ-027), and SHALL be zero when disp_valid is low.
REQ-020 When disp_valid and disp_ready are both high at the edge, the selected entry SHALL move READY->EXEC; only one dispatch is allowed per cycle.
REQ-021 An EXEC entry SHALL move to FREE at the edge where cdb_valid is high and cdb_tag equals its tag; a matching CDB tag on a non-EXEC entry SHALL NOT free that entry.
REQ-022 A freed entry SHALL NOT be re-issued in the same cycle it is freed: issue_ready and issue_tag use pre-edge state.
REQ-023 flush high: all entries go to FREE at the edge, and issue, dispatch and CDB updates in that cycle are ignored.
REQ-024 free_count SHALL equal the number of FREE entries; it updates together with busy_vec.
REQ-025 issue_valid while issue_ready is low SHALL have no effect; the source must hold the request.

Reset
REQ-026 rst_n low SHALL, asynchronously, place all entries in FREE and clear operands, tags and age state; outputs then read issue_ready=1, issue_tag=TAG_BASE, disp_valid=0, disp_*=0, busy_vec=0, free_count=NUM_ENTRIES. Reset asserted mid-operation discards all in-flight entries.

Configuration
REQ-027 Macro RS_POOL_AGE_ORDER_EN defined: an issue-order age matrix SHALL be kept, and dispatch selects the oldest READY entry. Undefined: no age state exists, and dispatch selects the lowest-index READY entry.

Verification
REQ-028 Reset, then issue ADD with qj=qk=0, vj=5, vk=7, disp_ready=1 -> issue_tag=1; next cycle disp_valid=1, disp_tag=1, disp_vj=5, disp_vk=7; following cycle busy_vec=0001 with the entry in EXEC.
REQ-029 Issue with qj=3 while cdb_valid=1, cdb_tag=3, cdb_data=0x10 -> entry READY next cycle with vj=0x10 (issue bypass).
REQ-030 Fill 4 entries -> issue_ready=0, free_count=0; CDB broadcasts tag 2 for the EXEC entry 1 -> next cycle issue_ready=1, issue_tag=2, free_count=1.
REQ-031 With RS_POOL_AGE_ORDER_EN: issue into entry 2 first, free entry 0, then issue into entry 0; both READY -> first dispatch disp_tag=3. Without the macro -> disp_tag=1.
REQ-032 With disp_ready=0 hold a READY entry for 3 cycles -> disp_* stable and state not EXEC; CDB for its own tag in this window -> entry not freed.
REQ-033 flush with 3 busy entries plus a simultaneous issue -> next cycle busy_vec=0, free_count=4, disp_valid=0; assert rst_n low mid-dispatch -> outputs immediately take their reset values.
